// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key-schedule engine: expands one round per cycle into an
// 11-entry round-key register file with a registered random-access read port.
module key_schedule_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    input  logic [3:0]       rd_addr,
    output logic [KEY_W-1:0] rk_out
);

    generate
        if (NUM_ROUNDS != 10 || KEY_W != 128) begin : g_bad_params
            $error("key_schedule_ctrl supports only AES-128 (NUM_ROUNDS=10, KEY_W=128)");
        end
    endgenerate

    localparam int         NUM_KEYS   = NUM_ROUNDS + 1;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         round_reg;
    logic [7:0]         rcon_reg;
    logic [KEY_W-1:0]   work_reg;
    logic               done_reg;
    logic               keys_valid_reg;
    logic [KEY_W-1:0]   rk_out_reg;

    logic               accept;
    logic               expanding;
    logic               last_round;
    logic [31:0]        rot_word;
    logic [31:0]        sub_word;
    logic [31:0]        temp_word;
    logic [31:0]        w0_next, w1_next, w2_next, w3_next;
    logic [KEY_W-1:0]   next_key;
    logic [7:0]         rcon_next;
    logic [KEY_W-1:0]   rk_file [0:NUM_KEYS-1];

    // Column word 3 holds bytes 12..15; rotating brings byte 13 into byte 0.
    assign rot_word = {work_reg[103:96], work_reg[127:104]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_word[8*gi +: 8] = SBOX[rot_word[8*gi +: 8]];
        end
    endgenerate

    assign temp_word = sub_word ^ {24'h0, rcon_reg};
    assign w0_next   = work_reg[31:0]   ^ temp_word;
    assign w1_next   = work_reg[63:32]  ^ w0_next;
    assign w2_next   = work_reg[95:64]  ^ w1_next;
    assign w3_next   = work_reg[127:96] ^ w2_next;
    assign next_key  = {w3_next, w2_next, w1_next, w0_next};
    assign rcon_next = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);

    always_comb begin
        state_next = state_reg;
        key_ready  = 1'b0;
        expanding  = 1'b0;
        accept     = 1'b0;
        last_round = (round_reg == LAST_ROUND);
        case (state_reg)
            IDLE: begin
                key_ready = 1'b1;
                accept    = key_valid;
                if (key_valid) state_next = EXPAND;
            end
            EXPAND: begin
                expanding = 1'b1;
                if (last_round) state_next = READY;
            end
            READY: begin
                key_ready = 1'b1;
                accept    = key_valid;
                if (key_valid) state_next = EXPAND;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            round_reg      <= 4'd0;
            rcon_reg       <= 8'h01;
            work_reg       <= '0;
            done_reg       <= 1'b0;
            keys_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            if (accept) begin
                work_reg       <= key_in;
                round_reg      <= 4'd1;
                rcon_reg       <= 8'h01;
                keys_valid_reg <= 1'b0;
            end else if (expanding) begin
                work_reg  <= next_key;
                rcon_reg  <= rcon_next;
                round_reg <= round_reg + 4'd1;
                if (last_round) begin
                    round_reg      <= 4'd0;
                    done_reg       <= 1'b1;
                    keys_valid_reg <= 1'b1;
                end
            end
        end
    end

    // Entry 0 takes the cipher key on accept; entry r takes round r's result.
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_rk
            logic [KEY_W-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (gi == 0 && accept) begin
                    entry_reg <= key_in;
                end else if (gi != 0 && expanding && round_reg == 4'(gi)) begin
                    entry_reg <= next_key;
                end
            end
            assign rk_file[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rk_out_reg <= '0;
        end else if (rd_addr <= LAST_ROUND) begin
            rk_out_reg <= rk_file[rd_addr];
        end else begin
            rk_out_reg <= '0;
        end
    end

    assign busy       = (state_reg == EXPAND);
    assign done       = done_reg;
    assign keys_valid = keys_valid_reg;
    assign rk_out     = rk_out_reg;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl against a word-level AES-128 key
// expansion model whose S-box is derived from GF(2^8) inversion.
module tb_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rd_addr = 4'd0;
    logic [127:0] rk_out;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_tb [256];
    logic [127:0] exp_rk  [11];

    key_schedule_ctrl #(.NUM_ROUNDS(10), .KEY_W(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_addr    (rd_addr),
        .rk_out     (rk_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box = affine transform of the multiplicative inverse in GF(2^8).
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_tb[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                t = {sbox_tb[t[31:24]], sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]]};
                t = t ^ {24'h0, rc};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            exp_rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic present_key(input logic [127:0] k);
        key_valid = 1'b1;
        key_in    = k;
        @(negedge clk);
        key_valid = 1'b0;
        check_val("busy_after_accept", busy, 1);
        check_val("kv_low_after_accept", keys_valid, 0);
    endtask

    task automatic wait_done(input string tag, input int expected);
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_latency"}, n, expected);
    endtask

    task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
        rd_addr = a;
        @(negedge clk);
        d = rk_out;
    endtask

    task automatic check_all(input string tag, input logic expect_zero);
        logic [127:0] d;
        for (int r = 0; r < 11; r++) begin
            read_rk(4'(r), d);
            check_val($sformatf("%s_rk%0d", tag, r), d, expect_zero ? 128'h0 : exp_rk[r]);
        end
    endtask

    task automatic full_key(input string tag, input logic [127:0] k);
        model_expand(k);
        present_key(k);
        wait_done(tag, 10);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, done, 0);
        check_val({tag, "_kv"}, keys_valid, 1);
        check_val({tag, "_ready"}, key_ready, 1);
        check_all(tag, 1'b0);
        $display("key %h expanded rk10=%h", k, exp_rk[10]);
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] key_a;
        logic [127:0] key_b;
        int low;
        build_sbox();

        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_val("rst_key_ready", key_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_keys_valid", keys_valid, 0);
        check_all("rst", 1'b1);

        // Known-answer keys
        full_key("fips", 128'h0f0e0d0c0b0a09080706050403020100);
        check_val("fips_rk1_kat", exp_rk[1], 128'hfe76abd6f178a6dafa72afd2fd74aad6);
        check_val("fips_rk10_kat", exp_rk[10], 128'hc5302b4d8ba707f3174a94e37f1d1113);
        full_key("kungfu", 128'h754620676e754b20796d207374616854);
        check_val("kungfu_rk1_kat", exp_rk[1], 128'h93a279d6e6e459b188911291f1fc32e2);
        check_val("kungfu_rk10_kat", exp_rk[10], 128'h266f313bfea4c0cc4a24a46df8defd28);

        // Address range and read latency
        read_rk(4'd11, d);
        check_val("addr11_zero", d, 0);
        read_rk(4'd15, d);
        check_val("addr15_zero", d, 0);
        read_rk(4'd1, d);
        check_val("lag_rk1", d, exp_rk[1]);
        rd_addr = 4'd10;
        #1;
        check_val("lag_hold", rk_out, exp_rk[1]);
        @(negedge clk);
        check_val("lag_rk10", rk_out, exp_rk[10]);

        // Random keys
        for (int i = 0; i < 3; i++)
            full_key($sformatf("rand%0d", i), {$urandom, $urandom, $urandom, $urandom});

        // Busy rejection: second key offered mid-expansion is dropped
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = ~key_a;
        model_expand(key_a);
        present_key(key_a);
        repeat (3) @(negedge clk);
        key_valid = 1'b1;
        key_in    = key_b;
        check_val("busy_key_ready_low", key_ready, 0);
        @(negedge clk);
        key_valid = 1'b0;
        wait_done("busyrej", 6);
        check_all("busyrej", 1'b0);
        $display("busy rejection key %h ignored", key_b);

        // Reset mid-expansion
        model_expand(key_b);
        present_key(key_b);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_ready", key_ready, 1);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_kv", keys_valid, 0);
        check_all("midrst", 1'b1);
        full_key("after_rst", key_b);

        // Back-to-back: next key offered on the done cycle
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom};
        model_expand(key_a);
        present_key(key_a);
        wait_done("b2b_first", 10);
        model_expand(key_b);
        present_key(key_b);
        low = 1;
        while (keys_valid !== 1'b1 && low < 20) begin
            @(negedge clk);
            if (keys_valid !== 1'b1) low++;
        end
        check_val("b2b_kv_low_cycles", low, 10);
        check_val("b2b_done", done, 1);
        check_all("b2b", 1'b0);
        $display("back-to-back key %h expanded", key_b);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
